// File: rtl/cyclic_code_pkg.sv
// Shared constants and GF(2) helpers for the (15,11) cyclic code decoder.
//   N, K, R  : codeword, info and parity lengths
//   GEN      : generator polynomial, bit i = coefficient of x^i
//   PAT      : x^(N-1) mod g, the syndrome signature of an error in the
//              bit currently leaving the emit buffer
package cyclic_code_pkg;

   localparam int N = 15;
   localparam int K = 11;
   localparam int R = N - K;
   localparam logic [R:0] GEN = 5'b10011;

   // One Horner step: (syn*x + b) mod g
   function automatic logic [R-1:0] gf2_mod_step(input logic [R-1:0] syn,
                                                 input logic         b,
                                                 input logic [R:0]   gen);
      logic [R:0] sh;
      sh = {syn, b};
      if (sh[R]) sh = sh ^ gen;
      return sh[R-1:0];
   endfunction

   // x^p mod g, evaluated at elaboration time
   function automatic logic [R-1:0] xpow_mod(input int p, input logic [R:0] gen);
      logic [R-1:0] syn;
      syn = {{(R-1){1'b0}}, 1'b1};
      for (int i = 0; i < p; i++) syn = gf2_mod_step(syn, 1'b0, gen);
      return syn;
   endfunction

   localparam logic [R-1:0] PAT = xpow_mod(N - 1, GEN);

endpackage

// File: rtl/cyclic_syndrome_lfsr.sv
// R-bit serial divider by g(x) (Horner form).
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_load_val (highest priority)
//   i_clear     : clear to zero
//   i_step      : shift in i_bit and reduce mod g
//   o_syn       : current remainder
module cyclic_syndrome_lfsr
   import cyclic_code_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [R-1:0] i_load_val,
   input  logic         i_clear,
   input  logic         i_step,
   input  logic         i_bit,
   output logic [R-1:0] o_syn
);

   logic [R-1:0] r_syn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_syn <= '0;
      end else if (i_load) begin
         r_syn <= i_load_val;
      end else if (i_clear) begin
         r_syn <= '0;
      end else if (i_step) begin
         r_syn <= gf2_mod_step(r_syn, i_bit, GEN);
      end
   end

   assign o_syn = r_syn;

endmodule

// File: rtl/cyclic_decoder_meggitt.sv
// Serial Meggitt decoder, single-error-correcting, for the (15,11) cyclic code.
// Receive stage accumulates the word and its syndrome; on the last bit the
// word moves to the emit stage, which streams it back out, flipping the bit
// whose rotated syndrome equals PAT.
//   clk        : clock
//   reset      : async active-low reset
//   enable     : qualifies 'in'
//   in         : received bit, x^(N-1) coefficient first
//   out        : corrected bit, same order
//   out_valid  : high N cycles per word
//   out_info   : high for the first K bits of each emitted word
//   err_flag   : high for a whole word whose syndrome was nonzero
module cyclic_decoder_meggitt
   import cyclic_code_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic in,
   output logic out,
   output logic out_valid,
   output logic out_info,
   output logic err_flag
);

   localparam int CW = $clog2(N + 1);

   // Only N-1 bits are kept: the oldest bit of a full word is never needed
   // because the word is handed over on the edge that accepts its last bit.
   logic [N-2:0]  r_rx_buf;
   logic [CW-1:0] r_rx_cnt;
   logic [N-1:0]  r_tx_buf;
   logic [CW-1:0] r_tx_cnt;
   logic          r_tx_err;
   logic          r_out, r_out_valid, r_out_info, r_err_flag;

   logic [R-1:0]  w_rx_syn, w_tx_syn, w_rx_syn_final;
   logic          w_last, w_tx_active, w_hit;

   assign w_last         = enable && (r_rx_cnt == CW'(N - 1));
   assign w_rx_syn_final = gf2_mod_step(w_rx_syn, in, GEN);
   assign w_tx_active    = (r_tx_cnt != '0);
   assign w_hit          = w_tx_active && (w_tx_syn == PAT);

   cyclic_syndrome_lfsr u_rx_syn (
      .clk        (clk),
      .rst_n      (reset),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_clear    (w_last),
      .i_step     (enable),
      .i_bit      (in),
      .o_syn      (w_rx_syn)
   );

   // Load has priority so a new word can arrive on the edge that emits the
   // previous word's last bit.
   cyclic_syndrome_lfsr u_tx_syn (
      .clk        (clk),
      .rst_n      (reset),
      .i_load     (w_last),
      .i_load_val (w_rx_syn_final),
      .i_clear    (w_hit),
      .i_step     (w_tx_active),
      .i_bit      (1'b0),
      .o_syn      (w_tx_syn)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_buf <= '0;
         r_rx_cnt <= '0;
      end else if (enable) begin
         r_rx_buf <= {r_rx_buf[N-3:0], in};
         r_rx_cnt <= w_last ? '0 : r_rx_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tx_buf <= '0;
         r_tx_cnt <= '0;
         r_tx_err <= 1'b0;
      end else if (w_last) begin
         r_tx_buf <= {r_rx_buf, in};
         r_tx_cnt <= CW'(N);
         r_tx_err <= (w_rx_syn_final != '0);
      end else if (w_tx_active) begin
         r_tx_buf <= {r_tx_buf[N-2:0], 1'b0};
         r_tx_cnt <= r_tx_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_info  <= 1'b0;
         r_err_flag  <= 1'b0;
      end else if (w_tx_active) begin
         r_out       <= r_tx_buf[N-1] ^ w_hit;
         r_out_valid <= 1'b1;
         r_out_info  <= (r_tx_cnt > CW'(R));
         r_err_flag  <= r_tx_err;
      end else begin
         r_out       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_info  <= 1'b0;
         r_err_flag  <= 1'b0;
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign out_info  = r_out_info;
   assign err_flag  = r_err_flag;

endmodule

// File: tb/tb_cyclic_decoder_meggitt.sv
module tb_cyclic_decoder_meggitt;

   localparam int TN = 15;
   localparam int TK = 11;
   localparam int TR = 4;
   localparam logic [4:0] TG = 5'b10011;

   logic clk, rst_n, enable, in;
   logic out, out_valid, out_info, err_flag;

   cyclic_decoder_meggitt dut (
      .clk       (clk),
      .reset     (rst_n),
      .enable    (enable),
      .in        (in),
      .out       (out),
      .out_valid (out_valid),
      .out_info  (out_info),
      .err_flag  (err_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] word;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   t_first_bit = 0;
   int   first_valid_cyc = 0;
   int   run_len = 0;
   int   run_max = 0;
   int   mon_idx = 0;
   exp_t cur;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Polynomial remainder by long division, bit 14 = x^14
   function automatic logic [3:0] poly_rem(input logic [14:0] v);
      logic [14:0] t;
      t = v;
      for (int i = 14; i >= TR; i--)
         if (t[i]) t = t ^ (15'(TG) << (i - TR));
      return t[3:0];
   endfunction

   function automatic logic [14:0] encode(input logic [10:0] info);
      logic [14:0] c;
      c = {info, 4'b0000};
      return c | 15'(poly_rem(c));
   endfunction

   // Flip the single position whose syndrome matches; no-op on zero syndrome
   function automatic logic [14:0] decode(input logic [14:0] r);
      logic [3:0]  s;
      logic [14:0] d;
      logic        found;
      d = r;
      s = poly_rem(r);
      found = 1'b0;
      if (s != 4'd0)
         for (int j = 0; j < TN; j++)
            if (!found && poly_rem(15'(1) << j) == s) begin
               d[j]  = ~d[j];
               found = 1'b1;
            end
      return d;
   endfunction

   // Output monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_idx = 0;
         run_len = 0;
      end else if (out_valid) begin
         run_len++;
         if (run_len > run_max) run_max = run_len;
         if (mon_idx == 0) begin
            if (q.size() == 0) begin
               chk("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
               cur = q.pop_front();
               first_valid_cyc = cyc;
               mon_idx = 1;
            end
         end else begin
            mon_idx++;
         end
         if (mon_idx != 0) begin
            chk("out_bit", 32'(out), 32'(cur.word[TN - mon_idx]));
            chk("out_info", 32'(out_info), 32'((mon_idx - 1) < TK));
            chk("err_flag", 32'(err_flag), 32'(cur.err));
            if (mon_idx == TN) mon_idx = 0;
         end
      end else begin
         run_len = 0;
         if (mon_idx != 0) begin
            chk("valid_gap", 32'(out_valid), 32'd1);
            mon_idx = 0;
         end
         chk("idle_outs", 32'({out, out_info, err_flag}), 32'd0);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         enable = 1'b0;
         in     = 1'b0;
      end
   endtask

   task automatic send_word(input logic [14:0] w, input logic [14:0] exp_w, input logic exp_e,
                            input int n_bits, input int gap_pos, input int gap_len);
      exp_t e;
      if (n_bits == TN) begin
         e.word = exp_w;
         e.err  = exp_e;
         q.push_back(e);
      end
      for (int i = 0; i < n_bits; i++) begin
         if (i == gap_pos) idle(gap_len);
         @(negedge clk);
         if (i == 0) t_first_bit = cyc + 1;
         enable = 1'b1;
         in     = w[TN - 1 - i];
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      idle(1);
      while ((q.size() != 0 || mon_idx != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain_done", 32'(q.size() + mon_idx), 32'd0);
      idle(3);
   endtask

   initial begin
      logic [14:0] c, r;
      logic [14:0] cw[3];
      int          p1, p2, ne;

      rst_n = 1'b0; enable = 1'b0; in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_info", 32'(out_info), 32'd0);
      chk("rst_err", 32'(err_flag), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // 1 clean word + latency
      send_word(15'b000000000010011, 15'b000000000010011, 1'b0, TN, -1, 0);
      idle(20);
      chk("t1_latency", 32'(first_valid_cyc - t_first_bit), 32'd15);
      drain();

      // 2 MSB error, 3 parity LSB error
      send_word(15'b100000000010011, 15'b000000000010011, 1'b1, TN, -1, 0);
      send_word(15'b000000000010010, 15'b000000000010011, 1'b1, TN, -1, 0);
      drain();

      // 3 sweep of every single-error position, back to back
      c = encode(11'($urandom));
      for (int j = 0; j < TN; j++)
         send_word(c ^ (15'(1) << j), c, 1'b1, TN, -1, 0);
      drain();

      // 4 three words back to back, continuous out_valid
      run_max = 0;
      for (int k = 0; k < 3; k++) begin
         cw[k] = encode(11'($urandom));
         ne = $urandom_range(0, 1);
         r = (ne != 0) ? cw[k] ^ (15'(1) << $urandom_range(0, 14)) : cw[k];
         send_word(r, cw[k], 1'(ne), TN, -1, 0);
      end
      drain();
      chk("t4_run", 32'(run_max), 32'd45);

      // 5 gaps inside and between words
      for (int k = 0; k < 3; k++) begin
         c = encode(11'($urandom));
         r = c ^ (15'(1) << $urandom_range(0, 14));
         send_word(r, c, 1'b1, TN, $urandom_range(1, 14), 3);
         idle(3);
      end
      drain();

      // random words with 0/1/2 errors, occasional gaps, against the model
      for (int k = 0; k < 40; k++) begin
         c  = encode(11'($urandom));
         ne = $urandom_range(0, 2);
         r  = c;
         p1 = $urandom_range(0, 14);
         p2 = (p1 + $urandom_range(1, 14)) % TN;
         if (ne >= 1) r[p1] = ~r[p1];
         if (ne == 2) r[p2] = ~r[p2];
         send_word(r, decode(r), 1'(poly_rem(r) != 4'd0), TN,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : -1, $urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      drain();

      // 6 reset mid-word while the previous word is emitting
      c = encode(11'($urandom));
      send_word(c, c, 1'b0, TN, -1, 0);
      send_word(encode(11'($urandom)), 15'd0, 1'b0, 7, -1, 0);
      @(posedge clk);
      #1;
      chk("t6_pre_valid", 32'(out_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      enable = 1'b0;
      in = 1'b0;
      q.delete();
      #1;
      chk("t6_rst_outs", 32'({out, out_valid, out_info, err_flag}), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(2);
      c = encode(11'($urandom));
      r = c ^ (15'(1) << $urandom_range(0, 14));
      send_word(r, c, 1'b1, TN, -1, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
